// File: rtl/xgmii32_tx_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xgmii32_tx_framer_pkg
//  Description : Shared 32-bit XGMII types, control characters and the helper
//                that builds the word carrying an in-word Terminate.
//  Contents    : xgmii32_t      {ena, ctrl[3:0], data[31:0]}
//                XGMII_*        XGMII control / preamble byte codes
//                term_word()    {ctrl, data} for a partially filled eop beat
//  Revision    : 1.0  initial release
// ============================================================================
package xgmii32_tx_framer_pkg;

   typedef struct packed {
      logic        ena;
      logic [3:0]  ctrl;
      logic [31:0] data;
   } xgmii32_t;

   localparam logic [7:0] XGMII_IDLE  = 8'h07;
   localparam logic [7:0] XGMII_START = 8'hFB;
   localparam logic [7:0] XGMII_TERM  = 8'hFD;
   localparam logic [7:0] XGMII_ERR   = 8'hFE;
   localparam logic [7:0] XGMII_PRE   = 8'h55;
   localparam logic [7:0] XGMII_SFD   = 8'hD5;

   // Lanes below (4 - empty) keep payload, the first unused lane carries
   // Terminate and any lanes above it are Idle. With empty = 0 no lane is
   // free, so the word is returned as plain data.
   function automatic logic [35:0] term_word(input logic [31:0] data,
                                             input logic [1:0]  empty);
      logic [3:0]  ctrl;
      logic [31:0] dout;
      int          first_term;
      first_term = 4 - int'(empty);
      ctrl       = 4'h0;
      dout       = data;
      for (int i = 0; i < 4; i++) begin
         if (i == first_term) begin
            dout[8*i +: 8] = XGMII_TERM;
            ctrl[i]        = 1'b1;
         end else if (i > first_term) begin
            dout[8*i +: 8] = XGMII_IDLE;
            ctrl[i]        = 1'b1;
         end
      end
      return {ctrl, dout};
   endfunction

endpackage
`default_nettype wire

// File: rtl/xgmii32_tx_pacer.sv
`default_nettype none
// ============================================================================
//  Module      : xgmii32_tx_pacer
//  Description : Gearbox pacing for 32-bit XGMII transmit paths. Flags the
//                last clock of every PACE_PERIOD-clock window as a stall.
//  Ports       : clk       in   clock
//                rst       in   synchronous active-high reset
//                ena_next  out  1 when the word registered at the next edge
//                                is a real (ena=1) word
//  Revision    : 1.0  initial release
// ============================================================================
module xgmii32_tx_pacer #(
   parameter int PACE_PERIOD = 33,
   parameter bit PACE_EN     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   output logic ena_next
);

   localparam int              PC_W    = (PACE_PERIOD > 1) ? $clog2(PACE_PERIOD) : 1;
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(PACE_PERIOD - 1);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;

   always_comb begin
      pc_d     = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
      ena_next = (pc_q != PC_LAST) || !PACE_EN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/xgmii32_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : xgmii32_tx_framer
//  Description : Packet stream to 32-bit XGMII framer. Adds Start, preamble/
//                SFD, Terminate and inter-frame gap, paces output words for
//                the downstream gearbox and aborts frames with /E/ on
//                underrun or link loss.
//  Ports       : clk           in   clock (PMA tx domain)
//                rst           in   synchronous active-high reset
//                link_up       in   link usable
//                s_data[31:0]  in   payload, lane0 = [7:0] first on wire
//                s_valid       in   beat valid
//                s_ready       out  beat accepted on s_valid & s_ready
//                s_sop         in   first beat of frame
//                s_eop         in   last beat of frame
//                s_empty[1:0]  in   unused upper lanes on the eop beat
//                xgmii_tx      out  {ena, ctrl[3:0], data[31:0]}
//                underrun_cnt  out  saturating aborted-frame count
//                busy          out  framer not idle
//  Revision    : 1.0  initial release
// ============================================================================
module xgmii32_tx_framer
   import xgmii32_tx_framer_pkg::*;
#(
   parameter int PACE_PERIOD = 33,
   parameter bit PACE_EN     = 1'b1,
   parameter int IFG_WORDS   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        link_up,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        s_sop,
   input  logic        s_eop,
   input  logic [1:0]  s_empty,
   output xgmii32_t    xgmii_tx,
   output logic [15:0] underrun_cnt,
   output logic        busy
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_START    = 3'd1;
   localparam logic [2:0] ST_PREAMBLE = 3'd2;
   localparam logic [2:0] ST_PAYLOAD  = 3'd3;
   localparam logic [2:0] ST_TERM     = 3'd4;
   localparam logic [2:0] ST_IFG      = 3'd5;
   localparam logic [2:0] ST_DROP     = 3'd6;

   // The idle word emitted from IDLE counts as the last gap word, so IFG
   // itself only supplies IFG_WORDS-1 words. With a gap of one word or less
   // the IFG state is skipped entirely.
   localparam int         IFG_LAST      = (IFG_WORDS > 1) ? IFG_WORDS - 2 : 0;
   localparam logic [7:0] IFG_LAST_W    = 8'(IFG_LAST);
   localparam logic [2:0] ST_AFTER_TERM = (IFG_WORDS > 1) ? ST_IFG : ST_IDLE;

   localparam logic [35:0] W_IDLE  = {4'hF, {4{XGMII_IDLE}}};
   localparam logic [35:0] W_START = {4'b0001, XGMII_PRE, XGMII_PRE, XGMII_PRE, XGMII_START};
   localparam logic [35:0] W_PRE   = {4'b0000, XGMII_SFD, XGMII_PRE, XGMII_PRE, XGMII_PRE};
   localparam logic [35:0] W_TERM  = {4'hF, XGMII_IDLE, XGMII_IDLE, XGMII_IDLE, XGMII_TERM};
   localparam logic [35:0] W_ERR   = {4'hF, {4{XGMII_ERR}}};

   logic        ena_next;
   logic [2:0]  state_q,    state_d;
   logic        ena_q;
   logic [35:0] word_q,     word_d;
   logic [15:0] cnt_q,      cnt_d;
   logic [7:0]  ifg_q,      ifg_d;
   logic        eop_done_q, eop_done_d;
   logic        abort;

   xgmii32_tx_pacer #(
      .PACE_PERIOD (PACE_PERIOD),
      .PACE_EN     (PACE_EN)
   ) u_pacer (
      .clk      (clk),
      .rst      (rst),
      .ena_next (ena_next)
   );

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      cnt_d      = cnt_q;
      ifg_d      = (state_q == ST_IFG) ? ifg_q : 8'd0;
      eop_done_d = eop_done_q;
      abort      = 1'b0;

      // IDLE drops stray mid-frame beats; DROP drains an aborted frame up to
      // and including its eop regardless of pacing.
      case (state_q)
         ST_IDLE:    s_ready = s_valid & ~s_sop;
         ST_PAYLOAD: s_ready = ena_next;
         ST_DROP:    s_ready = ~eop_done_q;
         default:    s_ready = 1'b0;
      endcase

      if ((state_q == ST_DROP) && s_valid && s_ready && s_eop) begin
         eop_done_d = 1'b1;
      end

      if (ena_next) begin
         case (state_q)
            ST_IDLE: begin
               word_d = W_IDLE;
               if (s_valid && s_sop && link_up) begin
                  state_d = ST_START;
               end
            end
            ST_START: begin
               if (link_up) begin
                  word_d  = W_START;
                  state_d = ST_PREAMBLE;
               end else begin
                  abort = 1'b1;
               end
            end
            ST_PREAMBLE: begin
               if (link_up) begin
                  word_d  = W_PRE;
                  state_d = ST_PAYLOAD;
               end else begin
                  abort = 1'b1;
               end
            end
            ST_PAYLOAD: begin
               if (!s_valid || !link_up) begin
                  // On link loss the presented beat is still taken (s_ready
                  // is high); if it was the eop nothing is left to drain.
                  abort      = 1'b1;
                  eop_done_d = s_valid & s_eop;
               end else if (s_eop && (s_empty != 2'd0)) begin
                  word_d  = term_word(s_data, s_empty);
                  state_d = ST_AFTER_TERM;
               end else begin
                  word_d = {4'h0, s_data};
                  if (s_eop) begin
                     state_d = ST_TERM;
                  end
               end
            end
            ST_TERM: begin
               word_d  = W_TERM;
               state_d = ST_AFTER_TERM;
            end
            ST_IFG: begin
               word_d = W_IDLE;
               ifg_d  = ifg_q + 8'd1;
               if (ifg_q == IFG_LAST_W) begin
                  state_d = ST_IDLE;
               end
            end
            ST_DROP: begin
               word_d = W_IDLE;
               if (eop_done_d) begin
                  state_d    = ST_AFTER_TERM;
                  eop_done_d = 1'b0;
               end
            end
            default: begin
               word_d  = W_IDLE;
               state_d = ST_IDLE;
            end
         endcase

         // The error word replaces the word this step would have sent, so
         // it has no state of its own; the next state depends on whether
         // the aborted frame still has beats to drain.
         if (abort) begin
            word_d     = W_ERR;
            state_d    = eop_done_d ? ST_AFTER_TERM : ST_DROP;
            eop_done_d = 1'b0;
            cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ena_q      <= 1'b0;
         word_q     <= W_IDLE;
         cnt_q      <= 16'd0;
         ifg_q      <= 8'd0;
         eop_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ena_q      <= ena_next;
         word_q     <= word_d;
         cnt_q      <= cnt_d;
         ifg_q      <= ifg_d;
         eop_done_q <= eop_done_d;
      end
   end

   assign xgmii_tx     = {ena_q, word_q};
   assign underrun_cnt = cnt_q;
   assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_xgmii32_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xgmii32_tx_framer
//  Description : Directed self-checking bench for xgmii32_tx_framer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_xgmii32_tx_framer;
   import xgmii32_tx_framer_pkg::*;

   localparam logic [35:0] W_IDLE = 36'hF_07070707;

   logic        clk = 1'b0;
   logic        rst;
   logic        link_up;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_sop;
   logic        s_eop;
   logic [1:0]  s_empty;
   logic        s_ready,      s_ready2;
   xgmii32_t    xgmii_tx,     xgmii_tx2;
   logic [15:0] underrun_cnt, underrun_cnt2;
   logic        busy,         busy2;

   int n_cmp = 0;
   int n_err = 0;

   logic [35:0] mon_q[$];

   xgmii32_tx_framer #(.PACE_PERIOD(33), .PACE_EN(1'b1), .IFG_WORDS(3)) dut (
      .clk(clk), .rst(rst), .link_up(link_up), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .s_sop(s_sop), .s_eop(s_eop), .s_empty(s_empty),
      .xgmii_tx(xgmii_tx), .underrun_cnt(underrun_cnt), .busy(busy)
   );

   xgmii32_tx_framer #(.PACE_PERIOD(33), .PACE_EN(1'b0), .IFG_WORDS(3)) dut_nopace (
      .clk(clk), .rst(rst), .link_up(link_up), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready2), .s_sop(s_sop), .s_eop(s_eop), .s_empty(s_empty),
      .xgmii_tx(xgmii_tx2), .underrun_cnt(underrun_cnt2), .busy(busy2)
   );

   always #5 clk = ~clk;

   // Record every real (ena=1) output word of the paced instance.
   always @(negedge clk) begin
      if (xgmii_tx.ena === 1'b1) mon_q.push_back({xgmii_tx.ctrl, xgmii_tx.data});
   end

   task automatic bus_idle();
      @(negedge clk); #1;
      s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_empty = 2'd0; s_data = 32'd0;
   endtask

   task automatic count_idles(output int n);
      n = 0;
      while (mon_q.size() > 0 && mon_q[0] == W_IDLE) begin
         void'(mon_q.pop_front());
         n++;
      end
   endtask

   // Drives one frame; byte i of the frame is seed+i. gap_at inserts one
   // underrun cycle before that beat, drop_at lowers link_up with that beat.
   task automatic drive_frame(input int nbytes, input logic [7:0] seed, input int gap_at,
                              input int drop_at, input bit chk_stall, output int stalls);
      int          nbeats;
      int          budget;
      logic        rdy;
      logic        accepted;
      logic [31:0] d;
      nbeats = (nbytes + 3) / 4;
      stalls = 0;
      for (int b = 0; b < nbeats; b++) begin
         for (int l = 0; l < 4; l++) begin
            d[8*l +: 8] = ((4*b + l) < nbytes) ? seed + 8'(4*b + l) : 8'h00;
         end
         if (b == gap_at) begin
            rdy = 1'b0;
            budget = 100;
            while (!rdy && budget > 0) begin
               @(negedge clk); #1;
               s_valid = 1'b0;
               #1 rdy = s_ready;
               @(posedge clk);
               budget--;
            end
            if (!rdy) begin
               n_cmp++; n_err++;
               $display("FAIL gap_timeout: s_ready never high during underrun gap, required 1");
            end
         end
         accepted = 1'b0;
         budget   = 200;
         while (!accepted && budget > 0) begin
            @(negedge clk); #1;
            s_valid = 1'b1;
            s_data  = d;
            s_sop   = (b == 0);
            s_eop   = (b == nbeats - 1);
            s_empty = (b == nbeats - 1) ? 2'(nbeats*4 - nbytes) : 2'd0;
            if (b == drop_at) link_up = 1'b0;
            #1 rdy = s_ready;
            @(posedge clk); #1;
            if (chk_stall && xgmii_tx.ena === 1'b0) begin
               stalls++;
               n_cmp++;
               if (rdy !== 1'b0) begin
                  n_err++;
                  $display("FAIL stall_ready: s_ready=%0b on stall word, required 0", rdy);
               end
            end
            accepted = rdy;
            budget--;
         end
         if (!accepted) begin
            n_cmp++; n_err++;
            $display("FAIL beat_timeout: beat %0d never accepted, required acceptance", b);
            return;
         end
      end
   endtask

   // Expected word list built independently of the DUT: Start, preamble,
   // payload, then Terminate (separate or in-word) or /E/ at abort_at.
   task automatic check_frame(input string name, input int nbytes, input logic [7:0] seed,
                              input int abort_at);
      logic [35:0] exp_q[$];
      logic [35:0] got;
      logic [31:0] d;
      logic [3:0]  c;
      int          nbeats;
      int          idx;
      nbeats = (nbytes + 3) / 4;
      exp_q.push_back(36'h1_555555FB);
      exp_q.push_back(36'h0_D5555555);
      for (int b = 0; b < nbeats; b++) begin
         if (abort_at >= 0 && b == abort_at) begin
            exp_q.push_back(36'hF_FEFEFEFE);
            break;
         end
         for (int l = 0; l < 4; l++) begin
            idx = 4*b + l;
            if (idx < nbytes) begin
               d[8*l +: 8] = seed + 8'(idx); c[l] = 1'b0;
            end else if (idx == nbytes) begin
               d[8*l +: 8] = 8'hFD; c[l] = 1'b1;
            end else begin
               d[8*l +: 8] = 8'h07; c[l] = 1'b1;
            end
         end
         exp_q.push_back({c, d});
      end
      if (abort_at < 0 && (nbytes % 4) == 0) exp_q.push_back(36'hF_070707FD);

      while (mon_q.size() > 0 && mon_q[0] == W_IDLE) void'(mon_q.pop_front());
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (mon_q.size() == 0) begin
            n_err++;
            $display("FAIL %s word%0d: missing, required %h", name, i, exp_q[i]);
         end else begin
            got = mon_q.pop_front();
            if (got !== exp_q[i]) begin
               n_err++;
               $display("FAIL %s word%0d: got %h, required %h", name, i, got, exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset();
      logic exp_ena;
      rst = 1'b1; link_up = 1'b1;
      s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_empty = 2'd0; s_data = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (xgmii_tx !== 37'h0F07070707) begin n_err++; $display("FAIL rst_xgmii: got %h, required 0f07070707", xgmii_tx); end
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b, required 0", s_ready); end
      n_cmp++; if (underrun_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d, required 0", underrun_cnt); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
      n_cmp++; if (xgmii_tx2 !== 37'h0F07070707 || s_ready2 !== 1'b0 || underrun_cnt2 !== 16'd0 || busy2 !== 1'b0) begin
         n_err++; $display("FAIL rst_nopace: xgmii %h ready %b cnt %0d busy %b, required 0f07070707/0/0/0",
                           xgmii_tx2, s_ready2, underrun_cnt2, busy2);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 99; k++) begin
         @(posedge clk); #1;
         exp_ena = ((k % 33) != 0);
         n_cmp++;
         if (xgmii_tx.ena !== exp_ena) begin n_err++; $display("FAIL pace_ena clk%0d: got %b, required %b", k, xgmii_tx.ena, exp_ena); end
         n_cmp++;
         if (xgmii_tx2.ena !== 1'b1) begin n_err++; $display("FAIL nopace_ena clk%0d: got %b, required 1", k, xgmii_tx2.ena); end
      end
   endtask

   task automatic test_idle_discard();
      @(negedge clk); #1;
      s_valid = 1'b1; s_sop = 1'b0; s_data = 32'hDEADBEEF;
      #1;
      n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL idle_discard_ready: got %b, required 1", s_ready); end
      bus_idle();
      repeat (5) @(posedge clk);
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_discard_busy: got %b, required 0", busy); end
   endtask

   task automatic test_frame_64();
      int st, n;
      mon_q.delete();
      drive_frame(64, 8'h00, -1, -1, 1'b1, st);
      bus_idle();
      repeat (20) @(posedge clk);
      check_frame("f64", 64, 8'h00, -1);
      count_idles(n);
      n_cmp++; if (n < 3) begin n_err++; $display("FAIL f64_ifg: got %0d idles, required >=3", n); end
   endtask

   task automatic test_short_61();
      int st, n;
      mon_q.delete();
      drive_frame(61, 8'h74, -1, -1, 1'b1, st);
      bus_idle();
      repeat (20) @(posedge clk);
      check_frame("f61", 61, 8'h74, -1);
      count_idles(n);
      n_cmp++; if (n < 3) begin n_err++; $display("FAIL f61_ifg: got %0d idles, required >=3", n); end
   endtask

   task automatic test_back_to_back();
      int st, n;
      mon_q.delete();
      drive_frame(40, 8'h10, -1, -1, 1'b1, st);
      drive_frame(24, 8'h80, -1, -1, 1'b1, st);
      bus_idle();
      repeat (20) @(posedge clk);
      check_frame("b2b_a", 40, 8'h10, -1);
      count_idles(n);
      n_cmp++; if (n !== 3) begin n_err++; $display("FAIL b2b_gap: got %0d idles, required 3", n); end
      check_frame("b2b_b", 24, 8'h80, -1);
   endtask

   task automatic test_underrun();
      int st, n;
      mon_q.delete();
      drive_frame(32, 8'h20, 3, -1, 1'b0, st);
      bus_idle();
      repeat (30) @(posedge clk);
      check_frame("underrun", 32, 8'h20, 3);
      n_cmp++; if (underrun_cnt !== 16'd1) begin n_err++; $display("FAIL underrun_cnt: got %0d, required 1", underrun_cnt); end
      count_idles(n);
      n_cmp++; if (mon_q.size() != 0) begin n_err++; $display("FAIL underrun_drain: got %0d non-idle words after /E/, required 0", mon_q.size()); end
      drive_frame(20, 8'h44, -1, -1, 1'b1, st);
      bus_idle();
      repeat (20) @(posedge clk);
      check_frame("post_underrun", 20, 8'h44, -1);
   endtask

   task automatic test_pace_stall();
      int st;
      mon_q.delete();
      drive_frame(160, 8'h33, -1, -1, 1'b1, st);
      bus_idle();
      repeat (15) @(posedge clk);
      check_frame("stall", 160, 8'h33, -1);
      n_cmp++; if (st < 1) begin n_err++; $display("FAIL stall_seen: got %0d stall words while driving, required >=1", st); end
   endtask

   task automatic test_link_drop();
      int st, n, rdy_cnt;
      mon_q.delete();
      drive_frame(32, 8'hA0, -1, 3, 1'b0, st);
      bus_idle();
      repeat (20) @(posedge clk);
      check_frame("linkdrop", 32, 8'hA0, 3);
      n_cmp++; if (underrun_cnt !== 16'd2) begin n_err++; $display("FAIL linkdrop_cnt: got %0d, required 2", underrun_cnt); end
      @(negedge clk); #1;
      s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b0; s_data = 32'h5F5E5D5C;
      rdy_cnt = 0;
      repeat (60) begin
         @(negedge clk); #2;
         if (s_ready) rdy_cnt++;
      end
      n_cmp++; if (rdy_cnt != 0) begin n_err++; $display("FAIL linkdown_ready: got %0d ready cycles, required 0", rdy_cnt); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL linkdown_busy: got %b, required 0", busy); end
      count_idles(n);
      n_cmp++; if (mon_q.size() != 0) begin n_err++; $display("FAIL linkdown_start: got %0d non-idle words, required 0", mon_q.size()); end
      link_up = 1'b1;
      drive_frame(24, 8'h5C, -1, -1, 1'b1, st);
      bus_idle();
      repeat (20) @(posedge clk);
      check_frame("after_link", 24, 8'h5C, -1);
   endtask

   initial begin
      test_reset();
      test_idle_discard();
      test_frame_64();
      test_short_61();
      test_back_to_back();
      test_underrun();
      test_pace_stall();
      test_link_drop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
